dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter for the single-port 256x16 data memory used by the processor datapath.
- Port 0 is the processor controller's load/store path. Port 1 is a secondary master, such as a program/data loader or debug access.
- Grants one memory access per cycle, muxes the address, write and data lines to the memory, and returns read data with a valid strobe.
- Policy is round-robin with a bounded burst hold.

Parameters:
- ADDR_W, 8, data memory address width
- DATA_W, 16, data memory word width
- MAX_HOLD, 4, maximum consecutive accepted beats an owner keeps while the other port waits; must be >= 1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  access request from port 0 / port 1
- we0, we1  in  1  write enable for a port (1 = write, 0 = read); valid with req
- addr0, addr1  in  ADDR_W  port address
- wdata0, wdata1  in  DATA_W  port write data
- gnt0, gnt1  out  1  beat accepted this cycle for that port
- rvalid0, rvalid1  out  1  rdata for that port is valid this cycle
- rdata  out  DATA_W  read data, shared by both ports, qualified by rvalid0/rvalid1
- mem_addr  out  ADDR_W  memory address
- mem_wr  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, available 1 cycle after the address is presented
- arb_state  out  2  current state, for debug/observation

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- States (arb_state encoding): IDLE=0, OWN0=1, OWN1=2. Encoding 3 is illegal and returns to IDLE on the next clock.
- Registers: state, last_owner (1 bit), hold_cnt (sized to count to MAX_HOLD), rvalid0/rvalid1.
- Reset values: state=IDLE, last_owner=1 (so port 0 wins the first tie), hold_cnt=0, rvalid0=rvalid1=0.
- Consequences of reset, via the combinational outputs: gnt0=gnt1=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- IDLE:
  - No grant is issued; there is a 1-cycle arbitration latency from req to the first gnt.
  - Single requester: go to OWN of that port.
  - Both requesting: go to OWN of the port that is not last_owner.
  - Clear hold_cnt on entry.
- OWNx:
  - gnt_x = req_x, combinational; the other port's gnt is 0.
  - A beat is accepted when req_x and gnt_x are both high.
  - The memory bus carries the owner's signals: mem_addr=addr_x, mem_wdata=wdata_x, mem_wr=gnt_x & we_x. When not granted, mem_addr=0, mem_wdata=0 and mem_wr=0.
  - An accepted beat increments hold_cnt and sets last_owner=x.
- Leaving OWNx:
  - req_x low: go to OWN of the other port if it is requesting, else IDLE.
  - Accepted beat where hold_cnt reaches MAX_HOLD and the other port is requesting: yield to OWN of the other port and clear hold_cnt.
  - If the other port is idle, the owner keeps the grant indefinitely; the count saturates.
  - Handoff between owners has no IDLE bubble; the new owner is granted in the very next cycle.
- Read return:
  - rvalid_x is registered high one cycle after an accepted read (we_x=0) by port x.
  - rdata = mem_rdata, passed through combinationally.
  - Back-to-back reads give rvalid on consecutive cycles.
  - A write never produces rvalid.
- Reset mid-operation: all state clears at once. A read accepted in the cycle before reset produces no rvalid.
- Requesters must hold req/we/addr/wdata stable until gnt.

Optional Feature:
- DMEM_ARB_FIXED_PRI_EN defined:
  - Port 0 has strict priority. In IDLE, both requesting goes to OWN0.
  - In OWN1, a rising req0 preempts at the next clock: the current port 1 beat still completes, then the state goes to OWN0.
  - MAX_HOLD is ignored for port 0.
- Undefined: the round-robin with MAX_HOLD policy described above.

Decomposition:
- Package dmem_arb_pkg: state localparams IDLE/OWN0/OWN1, the 2-bit state width, and defaults ADDR_W=8, DATA_W=16.
- No sub-module. The port mux and the pick logic are small enough to live inline in one FSM module.

Test Plan:
- Reset: rst_n=0 with req0=req1=1 -> gnt0=gnt1=0, mem_wr=0, arb_state=0. After release, first grant goes to port 0.
- Single write: req0=1, we0=1, addr0=0x12, wdata0=0xBEEF at cycle 0 -> cycle 1: gnt0=1, mem_wr=1, mem_addr=0x12, mem_wdata=0xBEEF. No rvalid0.
- Single read: port 1 reads 0x34, memory returns 0x00AA -> gnt1 at cycle 1; rvalid1=1 with rdata=0x00AA at cycle 2; rvalid0 stays 0.
- Contention, MAX_HOLD=4: both ports request continuously -> grants alternate 4 beats port 0, 4 beats port 1, with no idle cycle between owners. Then drop req1 -> port 0 is granted every cycle.
- Reset mid-read: port 0 read accepted, rst_n pulsed low before the next edge -> rvalid0 never asserts; state returns to IDLE.
- Macro DMEM_ARB_FIXED_PRI_EN: port 1 owns, then req0 rises -> port 1 gets exactly one more beat, port 0 is granted next cycle, and port 1 is starved while req0 stays high.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared constants for the two-port data-memory arbiter:
//               the arbiter state encoding, its width, and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Width of the arbiter state register and of the arb_state debug port.
    localparam int STATE_W = 2;

    // Arbiter state encoding. The value 3 is illegal and recovers to IDLE.
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] OWN0 = 2'd1;
    localparam logic [STATE_W-1:0] OWN1 = 2'd2;

    // Default geometry of the 256x16 data memory and the burst hold limit.
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_HOLD = 4;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester arbiter for a single-port data memory.
//               Port 0 is the processor load/store path, port 1 a secondary
//               master (loader / debug). One beat is accepted per cycle, the
//               owner's address/write/data are muxed onto the memory bus, and
//               read data comes back one cycle later with a per-port valid.
//
//               Default policy: round-robin, where an owner keeps the bus for
//               at most MAX_HOLD consecutive accepted beats while the other
//               port waits.
//               Build option DMEM_ARB_FIXED_PRI_EN: port 0 has strict
//               priority; a port 0 request preempts port 1 after the port 1
//               beat in flight, and MAX_HOLD no longer limits port 0.
//
// Ports       : clk, rst_n            clock, async active-low reset
//               req*_i/we*_i/addr*_i/wdata*_i   per-port request bundle
//               gnt*_o                beat accepted this cycle
//               rvalid*_o, rdata_o    read return (rdata shared by ports)
//               mem_addr_o/mem_wr_o/mem_wdata_o/mem_rdata_i  memory bus
//               arb_state_o           current arbiter state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req0_i,
    input  logic                we0_i,
    input  logic [ADDR_W-1:0]   addr0_i,
    input  logic [DATA_W-1:0]   wdata0_i,

    input  logic                req1_i,
    input  logic                we1_i,
    input  logic [ADDR_W-1:0]   addr1_i,
    input  logic [DATA_W-1:0]   wdata1_i,

    output logic                gnt0_o,
    output logic                gnt1_o,
    output logic                rvalid0_o,
    output logic                rvalid1_o,
    output logic [DATA_W-1:0]   rdata_o,

    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic [STATE_W-1:0]  arb_state_o
);

    // Counter wide enough to hold the value MAX_HOLD itself.
    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

`ifdef DMEM_ARB_FIXED_PRI_EN
    localparam bit FIXED_PRI = 1'b1;
`else
    localparam bit FIXED_PRI = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] state_q,      state_d;
    logic               last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]  hold_cnt_q,   hold_cnt_d;
    logic               rvalid0_q,    rvalid0_d;
    logic               rvalid1_q,    rvalid1_d;

    // Hold count after one more accepted beat; saturates at MAX_HOLD so an
    // owner that is never contested can keep streaming without wrapping.
    logic [HOLD_W-1:0]  hold_inc;
    logic               hold_full;

    always_comb begin
        if (hold_cnt_q >= HOLD_MAX) begin
            hold_inc = HOLD_MAX;
        end else begin
            hold_inc = hold_cnt_q + HOLD_W'(1);
        end
        hold_full = (hold_inc == HOLD_MAX);
    end

    // ------------------------------------------------------------------
    // Grants and memory bus mux
    // ------------------------------------------------------------------
    // A grant simply reflects the owner's request, so gnt doubles as the
    // "beat accepted" strobe for that port.
    always_comb begin
        gnt0_o = (state_q == OWN0) && req0_i;
        gnt1_o = (state_q == OWN1) && req1_i;
    end

    // The bus idles at all-zeros whenever nobody is granted, so a stale
    // address never leaks onto the memory.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wr_o    = 1'b0;
        if (gnt0_o) begin
            mem_addr_o  = addr0_i;
            mem_wdata_o = wdata0_i;
            mem_wr_o    = we0_i;
        end else if (gnt1_o) begin
            mem_addr_o  = addr1_i;
            mem_wdata_o = wdata1_i;
            mem_wr_o    = we1_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;

        case (state_q)
            IDLE: begin
                // No grant here: arbitration costs one cycle.
                hold_cnt_d = '0;
                if (req0_i && req1_i) begin
                    // Round-robin favours the port that did not go last.
                    if (FIXED_PRI || last_owner_q) begin
                        state_d = OWN0;
                    end else begin
                        state_d = OWN1;
                    end
                end else if (req0_i) begin
                    state_d = OWN0;
                end else if (req1_i) begin
                    state_d = OWN1;
                end
            end

            OWN0: begin
                if (!req0_i) begin
                    // Owner went quiet: hand straight over, no IDLE bubble.
                    hold_cnt_d = '0;
                    state_d    = req1_i ? OWN1 : IDLE;
                end else begin
                    last_owner_d = 1'b0;
                    if (!FIXED_PRI && req1_i && hold_full) begin
                        hold_cnt_d = '0;
                        state_d    = OWN1;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
            end

            OWN1: begin
                if (!req1_i) begin
                    hold_cnt_d = '0;
                    state_d    = req0_i ? OWN0 : IDLE;
                end else begin
                    last_owner_d = 1'b1;
                    // In fixed-priority builds any port 0 request preempts
                    // after the current port 1 beat completes.
                    if (req0_i && (FIXED_PRI || hold_full)) begin
                        hold_cnt_d = '0;
                        state_d    = OWN0;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
            end

            default: begin
                // Illegal encoding: recover without granting anything.
                hold_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Read valid follows an accepted read by exactly one cycle, matching the
    // one-cycle memory read latency. Writes never raise it.
    always_comb begin
        rvalid0_d = gnt0_o && !we0_i;
        rvalid1_d = gnt1_o && !we1_i;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // last_owner resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rvalid0_o   = rvalid0_q;
    assign rvalid1_o   = rvalid1_q;
    assign rdata_o     = mem_rdata_i;
    assign arb_state_o = state_q;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A behavioural model
//               tracks the owner, hold count and a shadow copy of memory;
//               directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef DMEM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [7:0]  addr  [2];
    logic [15:0] wdata [2];

    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wr;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [1:0]  arb_state;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_i      (req[0]),
        .we0_i       (we[0]),
        .addr0_i     (addr[0]),
        .wdata0_i    (wdata[0]),
        .req1_i      (req[1]),
        .we1_i       (we[1]),
        .addr1_i     (addr[1]),
        .wdata1_i    (wdata[1]),
        .gnt0_o      (gnt0),
        .gnt1_o      (gnt1),
        .rvalid0_o   (rvalid0),
        .rvalid1_o   (rvalid1),
        .rdata_o     (rdata),
        .mem_addr_o  (mem_addr),
        .mem_wr_o    (mem_wr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .arb_state_o (arb_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_val(int i);
        if (i == 8'h34) return 16'h00AA;
        return 16'((i * 16'h0101) ^ 16'h5A3C);
    endfunction

    // Memory: one-cycle read latency, read-before-write on the same address.
    logic [15:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            mem_rdata <= mem[mem_addr];
            if (mem_wr) mem[mem_addr] = mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner is -1 (nobody), 0 or 1.
    // ------------------------------------------------------------------
    int          m_own;
    int          m_last;
    int          m_cnt;
    bit          m_rv [2];
    logic [15:0] m_rd;
    bit          m_acc [2];
    logic [15:0] shadow [256];
    bit          obs_g0, obs_g1;

    task automatic model_reset();
        m_own  = -1;
        m_last = 1;
        m_cnt  = 0;
        m_rv[0] = 0; m_rv[1] = 0;
        m_acc[0] = 0; m_acc[1] = 0;
    endtask

    task automatic model_advance();
        bit nrv [2];
        int p, o;
        nrv[0] = 0; nrv[1] = 0;
        m_acc[0] = 0; m_acc[1] = 0;
        if (m_own >= 0 && req[m_own]) begin
            p = m_own;
            o = 1 - p;
            m_acc[p] = 1;
            m_last = p;
            if (we[p]) begin
                shadow[addr[p]] = wdata[p];
            end else begin
                nrv[p] = 1;
                m_rd   = shadow[addr[p]];
            end
            m_cnt = (m_cnt + 1 > MAX_HOLD) ? MAX_HOLD : m_cnt + 1;
            if (req[o] && (FIXED ? (p == 1) : (m_cnt == MAX_HOLD))) begin
                m_own = o;
                m_cnt = 0;
            end
        end else if (m_own >= 0) begin
            o = 1 - m_own;
            m_cnt = 0;
            m_own = req[o] ? o : -1;
        end else begin
            m_cnt = 0;
            if (req[0] && req[1]) m_own = FIXED ? 0 : 1 - m_last;
            else if (req[0])      m_own = 0;
            else if (req[1])      m_own = 1;
        end
        m_rv[0] = nrv[0];
        m_rv[1] = nrv[1];
    endtask

    // One cycle: inputs were driven just after a falling edge; compare the
    // DUT against the model, optionally pulse reset, advance the model, and
    // land on the next falling edge.
    task automatic step(input bit pulse_rst = 1'b0);
        bit          eg0, eg1;
        logic [7:0]  ea;
        logic [15:0] ed;
        logic        ew;
        #1;
        eg0 = (m_own == 0) && req[0];
        eg1 = (m_own == 1) && req[1];
        ea = eg0 ? addr[0]  : (eg1 ? addr[1]  : 8'h00);
        ed = eg0 ? wdata[0] : (eg1 ? wdata[1] : 16'h0000);
        ew = eg0 ? we[0]    : (eg1 ? we[1]    : 1'b0);
        obs_g0 = gnt0;
        obs_g1 = gnt1;
        check("gnt0", {31'd0, gnt0}, {31'd0, eg0});
        check("gnt1", {31'd0, gnt1}, {31'd0, eg1});
        check("mem_addr", {24'd0, mem_addr}, {24'd0, ea});
        check("mem_wr", {31'd0, mem_wr}, {31'd0, ew});
        check("mem_wdata", {16'd0, mem_wdata}, {16'd0, ed});
        check("rvalid0", {31'd0, rvalid0}, {31'd0, m_rv[0]});
        check("rvalid1", {31'd0, rvalid1}, {31'd0, m_rv[1]});
        check("arb_state", {30'd0, arb_state}, 32'(m_own + 1));
        if (m_rv[0] || m_rv[1]) check("rdata", {16'd0, rdata}, {16'd0, m_rd});
        if (pulse_rst) begin
            rst_n = 1'b0;
            #1;
            check("rst_state", {30'd0, arb_state}, 32'd0);
            check("rst_gnt0", {31'd0, gnt0}, 32'd0);
            model_reset();
            rst_n = 1'b1;
            #1;
        end
        model_advance();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        req[0] = 0; req[1] = 0;
        we[0] = 0;  we[1] = 0;
    endtask

    // Present one transaction on port p and hold it until the model grants.
    task automatic do_txn(input int p, input logic w, input logic [7:0] a, input logic [15:0] d);
        int budget;
        req[p] = 1; we[p] = w; addr[p] = a; wdata[p] = d;
        budget = 0;
        do begin
            step();
            budget++;
        end while (!m_acc[p] && budget < 20);
        if (!m_acc[p]) check("txn_timeout", 32'd1, 32'd0);
        req[p] = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    bit pend [2];

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        rst_n = 1'b0;
        req[0] = 1; req[1] = 1;
        we[0] = 0;  we[1] = 0;
        addr[0] = 8'h01; addr[1] = 8'h02;
        wdata[0] = 16'h0; wdata[1] = 16'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        // Reset holds everything off even with both ports requesting.
        check("reset_gnt0", {31'd0, gnt0}, 32'd0);
        check("reset_gnt1", {31'd0, gnt1}, 32'd0);
        check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("reset_state", {30'd0, arb_state}, 32'd0);
        check("reset_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First tie after reset goes to port 0.
        step();
        step();
        check("first_tie_p0", {31'd0, obs_g0}, 32'd1);
        drive_idle();
        step(); step(); step();

        // Single write, then single read from port 1.
        do_txn(0, 1'b1, 8'h12, 16'hBEEF);
        step(); step();
        do_txn(1, 1'b0, 8'h34, 16'h0000);
        check("read_data_0x34", {16'd0, m_rd}, 32'h00AA);
        step(); step();

        // Sustained contention.
        do_reset();
        req[0] = 1; we[0] = 0; addr[0] = 8'h10;
        req[1] = 1; we[1] = 0; addr[1] = 8'h20;
        step();
        for (int k = 0; k < 16; k++) begin
            step();
            check("rr_gnt0", {31'd0, obs_g0}, FIXED ? 32'd1 : 32'(((k / MAX_HOLD) % 2) == 0));
            check("rr_gnt1", {31'd0, obs_g1}, FIXED ? 32'd0 : 32'(((k / MAX_HOLD) % 2) == 1));
        end
        req[1] = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("solo_gnt0", {31'd0, obs_g0}, 32'd1);
        end
        drive_idle();
        step(); step();

        // Reset pulsed while a port 0 read is being accepted.
        req[0] = 1; we[0] = 0; addr[0] = 8'h40;
        step();
        step(1'b1);
        req[0] = 0;
        step();
        check("no_rvalid_after_rst", {31'd0, rvalid0}, 32'd0);
        step(); step();

`ifdef DMEM_ARB_FIXED_PRI_EN
        // Port 1 owns, then port 0 arrives: one more port 1 beat, then port 0.
        req[1] = 1; we[1] = 0; addr[1] = 8'h50;
        step(); step(); step();
        req[0] = 1; we[0] = 0; addr[0] = 8'h60;
        step();
        check("pre_gnt1", {31'd0, obs_g1}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            step();
            check("pri_gnt0", {31'd0, obs_g0}, 32'd1);
            check("pri_starve1", {31'd0, obs_g1}, 32'd0);
        end
        drive_idle();
        step(); step();
`endif

        // Randomized traffic with varying request intensity per phase.
        pend[0] = 0; pend[1] = 0;
        for (int ph = 0; ph < 4; ph++) begin
            int r0, r1;
            r0 = (ph == 1) ? 95 : 30 + ph * 20;
            r1 = (ph == 2) ? 95 : 70 - ph * 15;
            for (int c = 0; c < 200; c++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!pend[p] && $urandom_range(99) < (p == 0 ? r0 : r1)) begin
                        pend[p]  = 1;
                        we[p]    = $urandom_range(1);
                        addr[p]  = 8'($urandom_range(255));
                        wdata[p] = 16'($urandom);
                    end
                    req[p] = pend[p];
                end
                step();
                for (int p = 0; p < 2; p++) if (m_acc[p]) pend[p] = 0;
            end
        end
        drive_idle();
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
